// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants and state encoding for the 8-requester round-robin mux arbiter.
package mux8_rr_arbiter_pkg;

    localparam int unsigned N     = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/mux8.sv
// Shared 8-to-1 single-bit multiplexer.
module mux8
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [N-1:0]     in,
    input  logic [SEL_W-1:0] sel,
    output logic             out
);

    assign out = in[sel];

endmodule

// File: rtl/rr_pick8.sv
// Rotating-priority encoder: first set req bit scanning start, start+1, ... modulo 8.
module rr_pick8
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] start,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [2*N-1:0]   req_dbl;
    logic [N-1:0]     rot;
    logic [SEL_W-1:0] off;

    assign req_dbl = {req, req} >> start;
    assign rot     = req_dbl[N-1:0];
    assign any     = |req;

    // Lowest set bit of the rotated vector is the offset from start.
    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
    end

    assign idx = start + off;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8-to-1 mux; holds a grant for up to MAX_HOLD transfers.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     I,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             out_data,
    output logic [SEL_W-1:0] sel,
    output logic [N-1:0]     grant,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic [SEL_W-1:0] start_c;
    logic             transfer_c;
    logic             rel_c;

    // While granted, the next winner search starts after the current grantee.
    assign start_c = (state_q == GRANT) ? sel_q + SEL_W'(1) : last_q + SEL_W'(1);

    rr_pick8 u_pick (
        .req   (req),
        .start (start_c),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    mux8 u_mux (
        .in  (I),
        .sel (sel_q),
        .out (out_data)
    );

    assign out_valid  = (state_q == GRANT) && req[sel_q];
    assign transfer_c = out_valid && out_ready;
    assign rel_c      = (state_q == GRANT) &&
                        (!req[sel_q] || (transfer_c && (hold_cnt_q == CNT_W'(MAX_HOLD - 1))));

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        grant_d    = grant_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = GRANT;
                    sel_d      = pick_idx;
                    grant_d    = N'(1) << pick_idx;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (rel_c) begin
                    last_d     = sel_q;
                    hold_cnt_d = '0;
                    if (pick_any) begin
                        sel_d   = pick_idx;
                        grant_d = N'(1) << pick_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (transfer_c) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            grant_q    <= '0;
            last_q     <= SEL_W'(N - 1);
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign sel   = sel_q;
    assign grant = grant_q;
    assign busy  = (state_q == GRANT);

endmodule
